rev_serial_adder: RTL
=====================

# rev_serial_adder

Parametrised, bit-serial reversible adder/subtractor for the reversible microprocessor datapath; successor to the single-bit reversible full adder cell. Processes WIDTH-bit operands DIGIT bits per clock under a start/busy/done handshake. In forward mode it computes (a, b, cin) -> (a, a+b+cin, cout). In reverse (uncompute) mode it maps (a, s, cin) -> (a, s-a-cin, borrow), so a forward pass followed by a reverse pass restores b and returns borrow equal to the original cout.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; WIDTH must be a multiple of DIGIT. N = WIDTH/DIGIT.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = forward add, 1 = reverse (subtract/uncompute)
- a  input  WIDTH  control operand; passed through unchanged
- b  input  WIDTH  target operand (b in forward mode, s in reverse mode)
- cin  input  1  carry-in (forward) or borrow-in (reverse)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- a_out  output  WIDTH  copy of latched a (reversible passthrough)
- y  output  WIDTH  forward: (a+b+cin) mod 2^WIDTH; reverse: (b-a-cin) mod 2^WIDTH
- c_out  output  1  forward: carry out of bit WIDTH-1; reverse: borrow out of bit WIDTH-1

## Operation
- States: IDLE, RUN.
- IDLE: busy=0. start=1 at an edge latches a, b, cin and mode, clears the digit counter, and moves to RUN.
- RUN: busy=1. Each edge processes digit d (bits d*DIGIT .. d*DIGIT+DIGIT-1, LSB digit first) through DIGIT chained reversible full-adder or subtractor cells.
  - The carry/borrow register carries between digits; it is initialised from cin.
  - The counter increments per edge. On the edge processing digit N-1:
    - y, a_out and c_out load the final values.
    - done pulses.
    - The state returns to IDLE.
- Forward bit: y_i = a_i ^ b_i ^ c; c' = maj(a_i, b_i, c).
- Reverse bit: y_i = b_i ^ a_i ^ c; c' = (~b_i & a_i) | (~(b_i ^ a_i) & c).
- mode and operands are frozen for the whole operation. Input changes during RUN have no effect.
- start while busy=1 is ignored and is not queued.
- y, a_out and c_out hold their values from the last completion until the next completion. They never show partial results.
- Reset (rst_n low, at any time, including mid-RUN) aborts the operation:
  - state = IDLE, busy = 0, done = 0.
  - y = 0, a_out = 0, c_out = 0.
  - Internal counter, carry and shift registers are cleared.
- After rst_n deasserts, the first edge with start=1 begins a fresh operation.

## Timing
- Start accepted at edge k. busy=1 from just after edge k.
- Digits are processed at edges k+1 .. k+N.
- After edge k+N: done=1, busy=0, results valid. done falls after edge k+N+1.
- Latency from start acceptance to done is N cycles, e.g. 8 for WIDTH=8/DIGIT=1 and 2 for WIDTH=8/DIGIT=4.
- Back-to-back: start=1 while done=1 (edge k+N+1) is accepted, giving one operation every N+1 cycles.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=8, DIGIT=1, forward a=0x70, b=0x4C, cin=0 -> y=0xBC, c_out=0, a_out=0x70; done exactly 8 cycles after start is accepted; busy high for those 8 cycles.
- Forward wrap: a=0xFF, b=0x01, cin=1 -> y=0x01, c_out=1. Then reverse with a=0xFF, b=0x01, cin=1 -> y=0x01, c_out=1, which recovers the original b and cout.
- Reverse no-borrow: a=0x2A, b=0x66, cin=0 -> y=0x3C, c_out=0.
- start pulsed again at cycles 3 and 5 of a running operation with different operands -> ignored; the first operation's result is unchanged and only one done pulse occurs.
- rst_n low during cycle 4 of RUN -> busy, done, y and c_out read 0 immediately (asynchronous). A new start after release completes normally with correct values.
- WIDTH=8, DIGIT=4, forward a=0x3C, b=0x2A, cin=0 -> y=0x66, c_out=0, done 2 cycles after start. Back-to-back start on the done cycle -> second result 3 cycles after the first.

Source files
------------

// File: rtl/rev_serial_adder.sv
// Bit-serial reversible adder/subtractor. It processes DIGIT bits per clock
// through a chain of reversible full-adder/subtractor cells.

module rev_fa_cell (
    input  logic i_mode,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_y,
    output logic o_c
);
    assign o_y = i_a ^ i_b ^ i_c;
    // Reverse mode computes the borrow of b - a - c. Forward mode computes the majority carry.
    assign o_c = i_mode ? ((~i_b & i_a) | (~(i_b ^ i_a) & i_c))
                        : ((i_a & i_b) | (i_a & i_c) | (i_b & i_c));
endmodule

module rev_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] y,
    output logic             c_out
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic             r_mode;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_ash;
    logic [WIDTH-1:0] r_bsh;
    logic [WIDTH-1:0] r_ysh;
    logic             r_done;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_aout;
    logic             r_cout;

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_ydig;
    logic [WIDTH-1:0] w_ynext;

    assign w_c[0] = r_c;

    for (genvar g = 0; g < DIGIT; g++) begin : g_cell
        rev_fa_cell u_cell (
            .i_mode (r_mode),
            .i_a    (r_ash[g]),
            .i_b    (r_bsh[g]),
            .i_c    (w_c[g]),
            .o_y    (w_ydig[g]),
            .o_c    (w_c[g+1])
        );
    end

    // The result digits enter at the top and shift down. After N digits the LSB digit sits at bit 0.
    assign w_ynext = (r_ysh >> DIGIT) | (WIDTH'(w_ydig) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_ash   <= '0;
            r_bsh   <= '0;
            r_ysh   <= '0;
            r_done  <= 1'b0;
            r_y     <= '0;
            r_aout  <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_mode  <= mode;
                    r_c     <= cin;
                    r_cnt   <= '0;
                    r_a     <= a;
                    r_ash   <= a;
                    r_bsh   <= b;
                    r_ysh   <= '0;
                    r_state <= S_RUN;
                end
            end else begin
                r_ash <= r_ash >> DIGIT;
                r_bsh <= r_bsh >> DIGIT;
                r_ysh <= w_ynext;
                r_c   <= w_c[DIGIT];
                r_cnt <= r_cnt + 1'b1;
                // The visible outputs update only on the final digit, so partial sums never leak.
                if (r_cnt == LAST) begin
                    r_y     <= w_ynext;
                    r_aout  <= r_a;
                    r_cout  <= w_c[DIGIT];
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = r_done;
    assign y     = r_y;
    assign a_out = r_aout;
    assign c_out = r_cout;
endmodule
